// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for sys_ctrl: command opcodes, operand register
// addresses and the sequencer state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR    = 8'hAA;
  localparam logic [7:0] CMD_RF_RD    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OPR  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOPR = 8'hDD;

  localparam logic [3:0] OPA_ADDR = 4'h0;
  localparam logic [3:0] OPB_ADDR = 4'h1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    TX_RD,
    TX_LSB,
    TX_MSB
  } state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == CMD_RF_WR) || (b == CMD_RF_RD) ||
           (b == CMD_ALU_OPR) || (b == CMD_ALU_NOPR);
  endfunction

endpackage

// File: rtl/sys_ctrl.sv
// Byte-command sequencer driving the register file, ALU and TX FIFO.
// Optional macro SYS_CTRL_CMD_ERR_EN adds a cmd_err pulse for discarded bytes.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    rx_p_data,
  input  logic                     rx_d_valid,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data,
  input  logic                     rf_rd_data_valid,
  input  logic [2*DATA_WIDTH-1:0]  alu_out,
  input  logic                     alu_out_valid,
  input  logic                     fifo_full,
  output logic [ADDR_WIDTH-1:0]    rf_address,
  output logic                     rf_wr_en,
  output logic [DATA_WIDTH-1:0]    rf_wr_data,
  output logic                     rf_rd_en,
  output logic                     alu_en,
  output logic [ALU_FUN_WIDTH-1:0] alu_fun,
  output logic                     clk_gate_en,
  output logic [DATA_WIDTH-1:0]    tx_p_data,
  output logic                     tx_d_valid,
`ifdef SYS_CTRL_CMD_ERR_EN
  output logic                     cmd_err,
`endif
  output logic                     clk_div_en
);

  state_e                   state_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic [2*DATA_WIDTH-1:0]  result_q;

  logic [ADDR_WIDTH-1:0]    rf_address_q;
  logic                     rf_wr_en_q;
  logic [DATA_WIDTH-1:0]    rf_wr_data_q;
  logic                     rf_rd_en_q;
  logic                     alu_en_q;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q;
  logic                     clk_gate_en_q;
  logic [DATA_WIDTH-1:0]    tx_p_data_q;
  logic                     tx_d_valid_q;

  // NOTE: every register here is written with <= so all state updates see
  // the pre-edge values; a blocking = would create ordering-dependent logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_data_q     <= '0;
      result_q      <= '0;
      rf_address_q  <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      rf_rd_en_q    <= 1'b0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_valid_q  <= 1'b0;
    end else begin
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      tx_d_valid_q <= 1'b0;

      case (state_q)
        IDLE: if (rx_d_valid) begin
          case (rx_p_data)
            CMD_RF_WR:    state_q <= WR_ADDR;
            CMD_RF_RD:    state_q <= RD_ADDR;
            CMD_ALU_OPR:  state_q <= ALU_A;
            CMD_ALU_NOPR: begin
              state_q       <= ALU_FUN;
              clk_gate_en_q <= 1'b1;
            end
            default:      state_q <= IDLE;
          endcase
        end
        WR_ADDR: if (rx_d_valid) begin
          wr_addr_q <= rx_p_data[ADDR_WIDTH-1:0];
          state_q   <= WR_DATA;
        end
        WR_DATA: if (rx_d_valid) begin
          rf_address_q <= wr_addr_q;
          rf_wr_data_q <= rx_p_data;
          rf_wr_en_q   <= 1'b1;
          state_q      <= IDLE;
        end
        RD_ADDR: if (rx_d_valid) begin
          rf_address_q <= rx_p_data[ADDR_WIDTH-1:0];
          rf_rd_en_q   <= 1'b1;
          state_q      <= RD_WAIT;
        end
        RD_WAIT: if (rf_rd_data_valid) begin
          rd_data_q <= rf_rd_data;
          state_q   <= TX_RD;
        end
        ALU_A: if (rx_d_valid) begin
          rf_address_q <= ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_q <= rx_p_data;
          rf_wr_en_q   <= 1'b1;
          state_q      <= ALU_B;
        end
        ALU_B: if (rx_d_valid) begin
          rf_address_q  <= ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_q  <= rx_p_data;
          rf_wr_en_q    <= 1'b1;
          clk_gate_en_q <= 1'b1;
          state_q       <= ALU_FUN;
        end
        ALU_FUN: if (rx_d_valid) begin
          alu_fun_q <= rx_p_data[ALU_FUN_WIDTH-1:0];
          alu_en_q  <= 1'b1;
          state_q   <= ALU_WAIT;
        end
        ALU_WAIT: if (alu_out_valid) begin
          result_q      <= alu_out;
          clk_gate_en_q <= 1'b0;
          state_q       <= TX_LSB;
        end
        // Each TX state advances only on a cycle the FIFO can take the byte.
        TX_RD: if (!fifo_full) begin
          tx_p_data_q  <= rd_data_q;
          tx_d_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        TX_LSB: if (!fifo_full) begin
          tx_p_data_q  <= result_q[DATA_WIDTH-1:0];
          tx_d_valid_q <= 1'b1;
          state_q      <= TX_MSB;
        end
        TX_MSB: if (!fifo_full) begin
          tx_p_data_q  <= result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_d_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SYS_CTRL_CMD_ERR_EN
  logic rx_drop;
  logic cmd_err_q;

  // NOTE: a default assignment ahead of the case keeps this purely
  // combinational; leaving any path unassigned would infer a latch.
  always_comb begin
    rx_drop = 1'b0;
    if (rx_d_valid) begin
      case (state_q)
        IDLE:                                        rx_drop = !is_opcode(rx_p_data);
        RD_WAIT, ALU_WAIT, TX_RD, TX_LSB, TX_MSB:    rx_drop = 1'b1;
        default:                                     rx_drop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_err_q <= 1'b0;
    else     cmd_err_q <= rx_drop;
  end

  assign cmd_err = cmd_err_q;
`endif

  assign rf_address  = rf_address_q;
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign rf_rd_en    = rf_rd_en_q;
  assign alu_en      = alu_en_q;
  assign alu_fun     = alu_fun_q;
  assign clk_gate_en = clk_gate_en_q;
  assign tx_p_data   = tx_p_data_q;
  assign tx_d_valid  = tx_d_valid_q;
  assign clk_div_en  = 1'b1;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: table of command transactions plus
// hand-written backpressure, dropped-byte and reset sequences.
module tb_sys_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_p_data;
  logic        rx_d_valid;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_data_valid;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        fifo_full;
  logic [3:0]  rf_address;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic        clk_gate_en;
  logic [7:0]  tx_p_data;
  logic        tx_d_valid;
  logic        clk_div_en;
`ifdef SYS_CTRL_CMD_ERR_EN
  logic        cmd_err;
`endif

  sys_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rx_p_data        (rx_p_data),
    .rx_d_valid       (rx_d_valid),
    .rf_rd_data       (rf_rd_data),
    .rf_rd_data_valid (rf_rd_data_valid),
    .alu_out          (alu_out),
    .alu_out_valid    (alu_out_valid),
    .fifo_full        (fifo_full),
    .rf_address       (rf_address),
    .rf_wr_en         (rf_wr_en),
    .rf_wr_data       (rf_wr_data),
    .rf_rd_en         (rf_rd_en),
    .alu_en           (alu_en),
    .alu_fun          (alu_fun),
    .clk_gate_en      (clk_gate_en),
    .tx_p_data        (tx_p_data),
    .tx_d_valid       (tx_d_valid),
`ifdef SYS_CTRL_CMD_ERR_EN
    .cmd_err          (cmd_err),
`endif
    .clk_div_en       (clk_div_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Pulse logs, sampled 1 time unit after each rising edge.
  logic [3:0] wr_a_log[$];
  logic [7:0] wr_d_log[$];
  logic [3:0] rd_a_log[$];
  logic [3:0] alu_f_log[$];
  logic       alu_cg_log[$];
  logic [7:0] tx_log[$];
  int         err_cnt;

  always @(posedge clk) begin
    #1;
    if (rf_wr_en) begin
      wr_a_log.push_back(rf_address);
      wr_d_log.push_back(rf_wr_data);
    end
    if (rf_rd_en)   rd_a_log.push_back(rf_address);
    if (alu_en) begin
      alu_f_log.push_back(alu_fun);
      alu_cg_log.push_back(clk_gate_en);
    end
    if (tx_d_valid) tx_log.push_back(tx_p_data);
`ifdef SYS_CTRL_CMD_ERR_EN
    if (cmd_err) err_cnt++;
`endif
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] q8(input logic [7:0] q[$], input int k);
    return (k < q.size()) ? {24'h0, q[k]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] q4(input logic [3:0] q[$], input int k);
    return (k < q.size()) ? {28'h0, q[k]} : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    wr_a_log.delete(); wr_d_log.delete(); rd_a_log.delete();
    alu_f_log.delete(); alu_cg_log.delete(); tx_log.delete();
    err_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_p_data  = b;
    rx_d_valid = 1'b1;
    @(negedge clk);
    rx_d_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic respond_rd(input logic [7:0] d);
    for (int i = 0; i < 30 && rd_a_log.size() == 0; i++) @(negedge clk);
    check("rd_en_seen", {31'h0, rd_a_log.size() > 0}, 32'h1);
    rf_rd_data       = d;
    rf_rd_data_valid = 1'b1;
    @(negedge clk);
    rf_rd_data_valid = 1'b0;
  endtask

  task automatic respond_alu(input logic [15:0] r);
    for (int i = 0; i < 30 && alu_f_log.size() == 0; i++) @(negedge clk);
    check("alu_en_seen", {31'h0, alu_f_log.size() > 0}, 32'h1);
    alu_out       = r;
    alu_out_valid = 1'b1;
    @(negedge clk);
    alu_out_valid = 1'b0;
  endtask

  typedef struct {
    int              nb;
    logic [3:0][7:0] b;
    bit              do_rd;
    logic [7:0]      rd_data;
    bit              do_alu;
    logic [15:0]     alu_res;
    int              n_wr;
    logic [1:0][3:0] wr_a;
    logic [1:0][7:0] wr_d;
    int              n_rd;
    logic [3:0]      rd_a;
    int              n_alu;
    logic [3:0]      fun;
    int              n_tx;
    logic [1:0][7:0] tx;
    logic [3:0]      addr_end;
    logic [3:0]      fun_end;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // nb, bytes(b[0] rightmost), rd?, rd data, alu?, alu result,
    // n_wr, wr addrs, wr data, n_rd, rd addr, n_alu, fun, n_tx, tx bytes, end addr, end fun
    vecs[0] = '{3, {8'h00, 8'h3C, 8'h05, 8'hAA}, 0, 8'h00, 0, 16'h0000,
                1, {4'h0, 4'h5}, {8'h00, 8'h3C}, 0, 4'h0, 0, 4'h0, 0, {8'h00, 8'h00}, 4'h5, 4'h0};
    vecs[1] = '{2, {8'h00, 8'h00, 8'h05, 8'hBB}, 1, 8'h3C, 0, 16'h0000,
                0, {4'h0, 4'h0}, {8'h00, 8'h00}, 1, 4'h5, 0, 4'h0, 1, {8'h00, 8'h3C}, 4'h5, 4'h0};
    vecs[2] = '{4, {8'h00, 8'h34, 8'h12, 8'hCC}, 0, 8'h00, 1, 16'h0046,
                2, {4'h1, 4'h0}, {8'h34, 8'h12}, 0, 4'h0, 1, 4'h0, 2, {8'h00, 8'h46}, 4'h1, 4'h0};
    vecs[3] = '{2, {8'h00, 8'h00, 8'h03, 8'hDD}, 0, 8'h00, 1, 16'h1234,
                0, {4'h0, 4'h0}, {8'h00, 8'h00}, 0, 4'h0, 1, 4'h3, 2, {8'h12, 8'h34}, 4'h1, 4'h3};
    vecs[4] = '{3, {8'h00, 8'h99, 8'h1F, 8'hAA}, 0, 8'h00, 0, 16'h0000,
                1, {4'h0, 4'hF}, {8'h00, 8'h99}, 0, 4'h0, 0, 4'h0, 0, {8'h00, 8'h00}, 4'hF, 4'h3};
    vecs[5] = '{2, {8'h00, 8'h00, 8'h1F, 8'hBB}, 1, 8'h99, 0, 16'h0000,
                0, {4'h0, 4'h0}, {8'h00, 8'h00}, 1, 4'hF, 0, 4'h0, 1, {8'h00, 8'h99}, 4'hF, 4'h3};

    rst = 1'b1;
    rx_p_data = 8'h00; rx_d_valid = 1'b0;
    rf_rd_data = 8'h00; rf_rd_data_valid = 1'b0;
    alu_out = 16'h0000; alu_out_valid = 1'b0;
    fifo_full = 1'b0;
    err_cnt = 0;
    idle(3);

    check("rst_rf_address",  {28'h0, rf_address}, 32'h0);
    check("rst_strobes",     {28'h0, rf_wr_en, rf_rd_en, alu_en, tx_d_valid}, 32'h0);
    check("rst_data",        {8'h0, rf_wr_data, tx_p_data, 4'h0, alu_fun}, 32'h0);
    check("rst_clk_gate_en", {31'h0, clk_gate_en}, 32'h0);
    check("rst_clk_div_en",  {31'h0, clk_div_en}, 32'h1);
`ifdef SYS_CTRL_CMD_ERR_EN
    check("rst_cmd_err",     {31'h0, cmd_err}, 32'h0);
`endif
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      clear_logs();
      for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].b[j]);
      if (vecs[i].do_rd)  respond_rd(vecs[i].rd_data);
      if (vecs[i].do_alu) respond_alu(vecs[i].alu_res);
      idle(8);
      check($sformatf("v%0d_wr_cnt", i), wr_a_log.size(), vecs[i].n_wr);
      for (int k = 0; k < vecs[i].n_wr; k++) begin
        check($sformatf("v%0d_wr%0d_addr", i, k), q4(wr_a_log, k), {28'h0, vecs[i].wr_a[k]});
        check($sformatf("v%0d_wr%0d_data", i, k), q8(wr_d_log, k), {24'h0, vecs[i].wr_d[k]});
      end
      check($sformatf("v%0d_rd_cnt", i), rd_a_log.size(), vecs[i].n_rd);
      if (vecs[i].n_rd > 0)
        check($sformatf("v%0d_rd_addr", i), q4(rd_a_log, 0), {28'h0, vecs[i].rd_a});
      check($sformatf("v%0d_alu_cnt", i), alu_f_log.size(), vecs[i].n_alu);
      if (vecs[i].n_alu > 0) begin
        check($sformatf("v%0d_alu_fun", i), q4(alu_f_log, 0), {28'h0, vecs[i].fun});
        check($sformatf("v%0d_alu_cg", i), {31'h0, alu_cg_log.size() > 0 && alu_cg_log[0]}, 32'h1);
      end
      check($sformatf("v%0d_tx_cnt", i), tx_log.size(), vecs[i].n_tx);
      for (int k = 0; k < vecs[i].n_tx; k++)
        check($sformatf("v%0d_tx%0d", i, k), q8(tx_log, k), {24'h0, vecs[i].tx[k]});
      check($sformatf("v%0d_addr_hold", i), {28'h0, rf_address}, {28'h0, vecs[i].addr_end});
      check($sformatf("v%0d_fun_hold", i), {28'h0, alu_fun}, {28'h0, vecs[i].fun_end});
      check($sformatf("v%0d_cg_off", i), {31'h0, clk_gate_en}, 32'h0);
      check($sformatf("v%0d_err", i), err_cnt, 0);
    end

    // FIFO backpressure: result held while full, then two single strobes.
    clear_logs();
    fifo_full = 1'b1;
    send_byte(8'hDD);
    check("bp_cg_in_alu_fun", {31'h0, clk_gate_en}, 32'h1);
    send_byte(8'h02);
    respond_alu(16'hABCD);
    idle(5);
    check("bp_no_tx_while_full", tx_log.size(), 0);
    check("bp_cg_dropped", {31'h0, clk_gate_en}, 32'h0);
    fifo_full = 1'b0;
    idle(6);
    check("bp_tx_cnt", tx_log.size(), 2);
    check("bp_tx_lsb", q8(tx_log, 0), 32'hCD);
    check("bp_tx_msb", q8(tx_log, 1), 32'hAB);
    check("bp_alu_fun", {28'h0, alu_fun}, 32'h2);

    // Dropped bytes: illegal opcode in IDLE, stray byte during ALU_WAIT.
    clear_logs();
    send_byte(8'h77);
    idle(3);
    check("ill_no_activity",
          wr_a_log.size() + rd_a_log.size() + alu_f_log.size() + tx_log.size(), 0);
    send_byte(8'hDD);
    send_byte(8'h05);
    send_byte(8'h11);
    check("ill_cg_in_wait", {31'h0, clk_gate_en}, 32'h1);
    respond_alu(16'h0102);
    idle(8);
    check("ill_alu_cnt", alu_f_log.size(), 1);
    check("ill_wr_cnt", wr_a_log.size(), 0);
    check("ill_tx_cnt", tx_log.size(), 2);
    check("ill_tx_lsb", q8(tx_log, 0), 32'h02);
    check("ill_tx_msb", q8(tx_log, 1), 32'h01);
    check("ill_alu_fun", {28'h0, alu_fun}, 32'h5);
`ifdef SYS_CTRL_CMD_ERR_EN
    check("ill_cmd_err_cnt", err_cnt, 2);
`endif

    // Back-to-back: a byte arriving as TX_RD returns to IDLE is dropped.
    clear_logs();
    fifo_full = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h07);
    respond_rd(8'h5A);
    idle(2);
    rx_p_data  = 8'hAA;
    rx_d_valid = 1'b1;
    fifo_full  = 1'b0;
    @(negedge clk);
    rx_d_valid = 1'b0;
    idle(2);
    send_byte(8'h03);
    send_byte(8'h44);
    idle(4);
    check("b2b_tx", q8(tx_log, 0), 32'h5A);
    check("b2b_no_wr", wr_a_log.size(), 0);

    // Reset in the middle of a write command.
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h03);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_addr", {28'h0, rf_address}, 32'h0);
    check("mid_rst_data", {16'h0, rf_wr_data, tx_p_data}, 32'h0);
    check("mid_rst_fun",  {28'h0, alu_fun}, 32'h0);
    check("mid_rst_ctl",  {27'h0, rf_wr_en, rf_rd_en, alu_en, tx_d_valid, clk_gate_en}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h55);
    idle(4);
    check("mid_rst_no_wr", wr_a_log.size(), 0);
    send_byte(8'hAA);
    send_byte(8'h06);
    send_byte(8'h55);
    idle(3);
    check("post_rst_wr_cnt", wr_a_log.size(), 1);
    check("post_rst_wr_addr", q4(wr_a_log, 0), 32'h6);
    check("post_rst_wr_data", q8(wr_d_log, 0), 32'h55);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
